// File: rtl/uart_fifo_mmio.sv
// UART MMIO window with RX/TX byte FIFOs, fill-level status and sticky overflow flags.
// Optional UART_FIFO_IRQ_EN adds an RX-threshold/overflow interrupt and its STATUS controls.
module uart_fifo_mmio #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16,
    parameter int LVL_W    = $clog2((RX_DEPTH > TX_DEPTH) ? RX_DEPTH : TX_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  rx_data
`ifdef UART_FIFO_IRQ_EN
    ,
    output logic        irq
`endif
);

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    if (!is_pow2(RX_DEPTH) || RX_DEPTH < 2) begin : g_bad_rx
        $error("RX_DEPTH must be a power of two >= 2");
    end
    if (!is_pow2(TX_DEPTH) || TX_DEPTH < 2) begin : g_bad_tx
        $error("TX_DEPTH must be a power of two >= 2");
    end
    if (LVL_W > 8) begin : g_bad_lvl
        $error("LVL_W must be <= 8");
    end

    localparam int RA_W = $clog2(RX_DEPTH);
    localparam int TA_W = $clog2(TX_DEPTH);
    localparam logic [LVL_W-1:0] RX_FULL = LVL_W'(RX_DEPTH);
    localparam logic [LVL_W-1:0] TX_FULL = LVL_W'(TX_DEPTH);

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_RX   = 2'd1;
    localparam logic [1:0] A_TX   = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    typedef struct packed {
        logic rx_avail;
        logic tx_free;
    } uart_ctrl_t;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [RA_W-1:0]  rx_wp;
    logic [RA_W-1:0]  rx_rp;
    logic [TA_W-1:0]  tx_wp;
    logic [TA_W-1:0]  tx_rp;
    logic [LVL_W-1:0] rx_level;
    logic [LVL_W-1:0] tx_level;
    logic             rx_ovf;
    logic             tx_ovf;

    logic rd_req, wr_req;
    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_pop, rx_push, rx_drop;
    logic tx_pop, tx_wr, tx_push, tx_drop;
    logic stat_wr;
    logic [7:0] rx_lvl8, tx_lvl8;
    logic [31:0] status_word;
    logic [31:0] rd_mux;
    uart_ctrl_t ctrl;

    assign rd_req   = req_valid & ~req_we;
    assign wr_req   = req_valid & req_we;
    assign rx_empty = (rx_level == '0);
    assign rx_full  = (rx_level == RX_FULL);
    assign tx_empty = (tx_level == '0);
    assign tx_full  = (tx_level == TX_FULL);

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign rx_pop  = rd_req & (req_addr == A_RX) & ~rx_empty;
    assign rx_push = rx_valid & (~rx_full | rx_pop);
    assign rx_drop = rx_valid & rx_full & ~rx_pop;
    assign tx_pop  = ~tx_empty & tx_ready;
    assign tx_wr   = wr_req & (req_addr == A_TX);
    assign tx_push = tx_wr & (~tx_full | tx_pop);
    assign tx_drop = tx_wr & tx_full & ~tx_pop;
    assign stat_wr = wr_req & (req_addr == A_STAT);

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rp];
    assign rx_ready = 1'b1;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_data;
        if (tx_push) tx_mem[tx_wp] <= req_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            tx_wp    <= '0;
            tx_rp    <= '0;
            rx_level <= '0;
            tx_level <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RA_W'(1);
            if (rx_pop)  rx_rp <= rx_rp + RA_W'(1);
            if (tx_push) tx_wp <= tx_wp + TA_W'(1);
            if (tx_pop)  tx_rp <= tx_rp + TA_W'(1);
            rx_level <= rx_level + LVL_W'(rx_push) - LVL_W'(rx_pop);
            tx_level <= tx_level + LVL_W'(tx_push) - LVL_W'(tx_pop);
        end
    end

    // A new overflow beats a simultaneous write-one-to-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ovf <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            if (rx_drop)                     rx_ovf <= 1'b1;
            else if (stat_wr & req_wdata[16]) rx_ovf <= 1'b0;
            if (tx_drop)                     tx_ovf <= 1'b1;
            else if (stat_wr & req_wdata[17]) tx_ovf <= 1'b0;
        end
    end

    always_comb begin
        rx_lvl8 = '0;
        tx_lvl8 = '0;
        rx_lvl8[LVL_W-1:0] = rx_level;
        tx_lvl8[LVL_W-1:0] = tx_level;
    end

`ifdef UART_FIFO_IRQ_EN
    logic [7:0] rx_thresh;
    logic [7:0] thr_eff;
    logic       irq_en;
    logic       unused_wdata;

    assign unused_wdata = ^{req_wdata[31:29], req_wdata[19:18], req_wdata[15:8]};
    assign thr_eff = (rx_thresh == 8'd0) ? 8'd1 : rx_thresh;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_thresh <= 8'd1;
            irq_en    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (stat_wr) begin
                rx_thresh <= req_wdata[27:20];
                irq_en    <= req_wdata[28];
            end
            irq <= irq_en & ((rx_lvl8 >= thr_eff) | rx_ovf | tx_ovf);
        end
    end

    assign status_word = {3'd0, irq_en, rx_thresh, 2'd0,
                          tx_ovf, rx_ovf, tx_lvl8, rx_lvl8};
`else
    logic unused_wdata;

    assign unused_wdata = ^{req_wdata[31:18], req_wdata[15:8]};
    assign status_word = {14'd0, tx_ovf, rx_ovf, tx_lvl8, rx_lvl8};
`endif

    assign ctrl.rx_avail = ~rx_empty;
    assign ctrl.tx_free  = ~tx_full;

    always_comb begin
        rd_mux = '0;
        unique case (req_addr)
            A_CTRL: rd_mux = {30'd0, ctrl};
            A_RX:   rd_mux = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp]};
            A_TX:   rd_mux = '0;
            A_STAT: rd_mux = status_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rd_req;
            if (rd_req) rsp_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Directed testbench for uart_fifo_mmio: register map, FIFO flow, overflow,
// W1C priority, pointer wrap, mid-operation reset and the optional interrupt.
module tb_uart_fifo_mmio;

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_RX   = 2'd1;
    localparam logic [1:0] A_TX   = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;
`ifdef UART_FIFO_IRQ_EN
    localparam logic [31:0] STAT_RST = 32'h0010_0000;
`else
    localparam logic [31:0] STAT_RST = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
`ifdef UART_FIFO_IRQ_EN
    logic        irq;
`endif

    int vectors = 0;
    int miscompares = 0;

    uart_fifo_mmio dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data)
`ifdef UART_FIFO_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_read(input logic [1:0] a, output logic v, output logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        v = rsp_valid;
        d = rsp_rdata;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic v;
        logic [31:0] d;
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = 2'd0;
        req_wdata = '0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_out got txv=%b rxr=%b rv=%b rd=%h want 0 1 0 0",
                     tx_valid, rx_ready, rsp_valid, rsp_rdata);
        end
        do_read(A_CTRL, v, d);
        vectors++;
        if (v !== 1'b1 || d !== 32'h1) begin
            miscompares++;
            $display("FAIL reset_ctrl got v=%b d=%h want v=1 d=00000001", v, d);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h1) begin
            miscompares++;
            $display("FAIL rsp_one_cycle got v=%b d=%h want v=0 d=00000001 held", rsp_valid, rsp_rdata);
        end
        do_read(A_RX, v, d);
        vectors++;
        if (v !== 1'b1 || d !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rx got v=%b d=%h want v=1 d=0", v, d);
        end
        do_read(A_TX, v, d);
        vectors++;
        if (v !== 1'b1 || d !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_txreg got v=%b d=%h want v=1 d=0", v, d);
        end
        do_read(A_STAT, v, d);
        vectors++;
        if (v !== 1'b1 || d !== STAT_RST) begin
            miscompares++;
            $display("FAIL reset_status got v=%b d=%h want v=1 d=%h", v, d, STAT_RST);
        end
    endtask

    task automatic test_tx_fifo();
        logic v;
        logic [31:0] d;
        logic [7:0] e;
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) do_write(A_TX, 32'h41 + i);
        do_read(A_CTRL, v, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL tx_full_ctrl got %h want 00000000", d);
        end
        do_read(A_STAT, v, d);
        vectors++;
        if (d !== (STAT_RST | 32'h1000)) begin
            miscompares++;
            $display("FAIL tx_full_level got %h want %h", d, STAT_RST | 32'h1000);
        end
        do_write(A_TX, 32'h51);
        do_read(A_STAT, v, d);
        vectors++;
        if (d !== (STAT_RST | 32'h2_1000)) begin
            miscompares++;
            $display("FAIL tx_ovf got %h want %h", d, STAT_RST | 32'h2_1000);
        end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e = 8'h41 + 8'(i);
            vectors++;
            if (tx_valid !== 1'b1 || tx_data !== e) begin
                miscompares++;
                $display("FAIL tx_order[%0d] got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, e);
            end
            @(negedge clk);
        end
        vectors++;
        if (tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_drained got tx_valid=%b want 0", tx_valid);
        end
        tx_ready = 1'b0;
        do_write(A_STAT, STAT_RST | 32'h2_0000);
        do_read(A_STAT, v, d);
        vectors++;
        if (d !== STAT_RST) begin
            miscompares++;
            $display("FAIL tx_ovf_clear got %h want %h", d, STAT_RST);
        end
    endtask

    task automatic test_rx_overflow();
        logic v;
        logic [31:0] d;
        for (int i = 0; i < 16; i++) push_rx(8'(i));
        push_rx(8'hAA);
        do_read(A_STAT, v, d);
        vectors++;
        if (d !== (STAT_RST | 32'h1_0010)) begin
            miscompares++;
            $display("FAIL rx_ovf got %h want %h", d, STAT_RST | 32'h1_0010);
        end
        do_read(A_CTRL, v, d);
        vectors++;
        if (d !== 32'h3) begin
            miscompares++;
            $display("FAIL rx_full_ctrl got %h want 00000003", d);
        end
        do_write(A_STAT, STAT_RST | 32'h1_0000);
        do_read(A_STAT, v, d);
        vectors++;
        if (d !== (STAT_RST | 32'h10)) begin
            miscompares++;
            $display("FAIL rx_w1c got %h want %h", d, STAT_RST | 32'h10);
        end
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = A_STAT;
        req_wdata = STAT_RST | 32'h1_0000;
        rx_valid  = 1'b1;
        rx_data   = 8'hBB;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        rx_valid  = 1'b0;
        do_read(A_STAT, v, d);
        vectors++;
        if (d !== (STAT_RST | 32'h1_0010)) begin
            miscompares++;
            $display("FAIL set_beats_clear got %h want %h", d, STAT_RST | 32'h1_0010);
        end
        do_write(A_STAT, STAT_RST | 32'h1_0000);
        for (int i = 0; i < 16; i++) begin
            do_read(A_RX, v, d);
            vectors++;
            if (v !== 1'b1 || d !== 32'(i)) begin
                miscompares++;
                $display("FAIL rx_order[%0d] got v=%b d=%h want v=1 d=%h", i, v, d, 32'(i));
            end
        end
        do_read(A_CTRL, v, d);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL rx_empty_ctrl got %h want 00000001", d);
        end
        do_read(A_RX, v, d);
        vectors++;
        if (v !== 1'b1 || d !== 32'h0) begin
            miscompares++;
            $display("FAIL rx_empty_read got v=%b d=%h want v=1 d=0", v, d);
        end
        do_read(A_STAT, v, d);
        vectors++;
        if (d !== STAT_RST) begin
            miscompares++;
            $display("FAIL rx_empty_level got %h want %h", d, STAT_RST);
        end
    endtask

    task automatic test_back_to_back();
        logic v;
        logic [31:0] d;
        logic [7:0] e;
        for (int i = 0; i < 16; i++) push_rx(8'h20 + 8'(i));
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = A_RX;
        rx_valid  = 1'b1;
        rx_data   = 8'h77;
        @(negedge clk);
        req_valid = 1'b0;
        rx_valid  = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h20) begin
            miscompares++;
            $display("FAIL simul_pop got v=%b d=%h want v=1 d=00000020", rsp_valid, rsp_rdata);
        end
        do_read(A_STAT, v, d);
        vectors++;
        if (d !== (STAT_RST | 32'h10)) begin
            miscompares++;
            $display("FAIL simul_level got %h want %h", d, STAT_RST | 32'h10);
        end
        for (int i = 0; i < 16; i++) begin
            e = (i == 15) ? 8'h77 : 8'h21 + 8'(i);
            do_read(A_RX, v, d);
            vectors++;
            if (d !== {24'd0, e}) begin
                miscompares++;
                $display("FAIL simul_order[%0d] got %h want %h", i, d, e);
            end
        end
        for (int i = 0; i < 40; i++) begin
            e = 8'(i * 37 + 5);
            push_rx(e);
            do_read(A_RX, v, d);
            vectors++;
            if (d !== {24'd0, e}) begin
                miscompares++;
                $display("FAIL wrap[%0d] got %h want %h", i, d, e);
            end
        end
        do_read(A_STAT, v, d);
        vectors++;
        if (d !== STAT_RST) begin
            miscompares++;
            $display("FAIL wrap_level got %h want %h", d, STAT_RST);
        end
    endtask

`ifdef UART_FIFO_IRQ_EN
    task automatic test_irq();
        logic v;
        logic [31:0] d;
        do_write(A_STAT, 32'h1040_0000);
        for (int i = 0; i < 3; i++) push_rx(8'(i + 1));
        @(negedge clk);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_below got %b want 0", irq);
        end
        push_rx(8'h04);
        @(negedge clk);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_at_thresh got %b want 1", irq);
        end
        do_read(A_STAT, v, d);
        vectors++;
        if (d !== 32'h1040_0004) begin
            miscompares++;
            $display("FAIL irq_status got %h want 10400004", d);
        end
        do_read(A_RX, v, d);
        @(negedge clk);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_after_pop got %b want 0", irq);
        end
        do_write(A_STAT, 32'h1000_0000);
        @(negedge clk);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_thresh0 got %b want 1", irq);
        end
        do_write(A_STAT, STAT_RST);
        @(negedge clk);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_disabled got %b want 0", irq);
        end
    endtask
`endif

    task automatic test_mid_reset();
        logic v;
        logic [31:0] d;
        push_rx(8'h5A);
        push_rx(8'h5B);
        do_write(A_TX, 32'hC3);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = A_STAT;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got rv=%b txv=%b want 0 0", rsp_valid, tx_valid);
        end
        do_read(A_STAT, v, d);
        vectors++;
        if (v !== 1'b1 || d !== STAT_RST) begin
            miscompares++;
            $display("FAIL mid_reset_status got v=%b d=%h want v=1 d=%h", v, d, STAT_RST);
        end
        do_read(A_RX, v, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset_rx got %h want 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_tx_fifo();
        test_rx_overflow();
        test_back_to_back();
`ifdef UART_FIFO_IRQ_EN
        test_irq();
`endif
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
